// File: rtl/store_narrow.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow
// Purpose  : Store-path narrowing unit. Takes a 32-bit register value and a
//            size/address from the MEM stage, replicates the value onto the
//            proper byte lanes, generates byte enables and performs a
//            request/grant write handshake with data memory. Misaligned and
//            illegal-size stores are rejected without touching memory, and a
//            memory that never grants is abandoned after TIMEOUT cycles.
// Ports    : clk, reset_n          - clock, async active-low reset
//            st_valid/st_ready     - store request handshake from pipeline
//            st_size/addr/data     - store size (00 B, 01 H, 10 W), address, data
//            mem_req/mem_gnt       - memory write request / grant
//            mem_addr/wdata/be     - word address, lane data, byte enables
//            done/err/err_code     - completion pulse and its status
//            store_count           - saturating count of successful stores
// Revision : 1.0 - initial release
// ============================================================================
module store_narrow #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1:0]       st_size,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] store_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  // Last value of the wait counter before the store is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [15:0] wait_cnt;

  logic        accept;
  logic        size_bad;
  logic        misalign;
  logic        fault;
  logic        granted;
  logic        timed_out;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign accept    = st_valid && st_ready;
  assign size_bad  = (st_size == 2'b11);
  assign misalign  = ((st_size == 2'b01) && st_addr[0]) ||
                     ((st_size == 2'b10) && (st_addr[1:0] != 2'b00));
  assign fault     = size_bad || misalign;
  assign granted   = (state == REQ) && mem_gnt;
  // Grant takes priority: a grant on the final wait cycle is a success.
  assign timed_out = (state == REQ) && !mem_gnt && (wait_cnt == WAIT_LAST);

  // Lane replication and byte-enable generation.
  always_comb begin
    lane_wdata = st_data;
    lane_be    = 4'b1111;
    case (st_size)
      2'b00: begin
        lane_wdata = {4{st_data[7:0]}};
        lane_be    = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{st_data[15:0]}};
        lane_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = st_data;
        lane_be    = 4'b1111;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = fault ? FAULT : REQ;
        end
      end
      REQ: begin
        if (granted || timed_out) begin
          next_state = IDLE;
        end
      end
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    st_ready = (state == IDLE);
    mem_req  = (state == REQ);
  end

  // --------------------------------------------------------------------------
  // Datapath: write-port registers, status pulses, counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_be      <= 4'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      store_count <= '0;
      wait_cnt    <= 16'd0;
    end else begin
      // Status outputs are single-cycle pulses unless set below.
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;

      if (accept) begin
        mem_addr  <= {st_addr[31:2], 2'b00};
        mem_wdata <= lane_wdata;
        // Rejected stores never reach memory, so no lanes are enabled.
        mem_be    <= fault ? 4'b0000 : lane_be;
        wait_cnt  <= 16'd0;
        if (fault) begin
          done     <= 1'b1;
          err      <= 1'b1;
          err_code <= size_bad ? CODE_ILLEGAL : CODE_MISALIGN;
        end
      end else if (granted) begin
        done <= 1'b1;
        if (store_count != {CNT_W{1'b1}}) begin
          store_count <= store_count + CNT_W'(1);
        end
      end else if (timed_out) begin
        done     <= 1'b1;
        err      <= 1'b1;
        err_code <= CODE_TIMEOUT;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_narrow
// Purpose  : Self-checking bench for store_narrow. A transaction-level model
//            (lane/fault functions plus per-cycle expected outputs maintained
//            by the stimulus thread) is compared with the DUT on every
//            falling edge; a few literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_narrow;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             st_valid;
  logic             st_ready;
  logic [1:0]       st_size;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             mem_req;
  logic             mem_gnt;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] store_count;

  // Expected outputs for the current cycle.
  logic        exp_ready;
  logic        exp_req;
  logic        exp_done;
  logic        exp_err;
  logic [1:0]  exp_code;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_be;
  logic        exp_be_zero;
  int          exp_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  store_narrow #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .store_count (store_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
  endtask

  // Lane data and byte enables a store of this size/address must produce.
  function automatic logic [35:0] lanes(input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] data);
    logic [31:0] w;
    logic [3:0]  b;
    case (size)
      2'b00: begin
        w = 32'(data[7:0]) * 32'h01010101;
        b = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w = 32'(data[15:0]) * 32'h00010001;
        b = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w = data;
        b = 4'b1111;
      end
    endcase
    return {b, w};
  endfunction

  function automatic logic [1:0] fault_of(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 2'b10;
    if (size == 2'b01 && addr[0]) return 2'b01;
    if (size == 2'b10 && addr[1:0] != 2'b00) return 2'b01;
    return 2'b00;
  endfunction

  // Compare process: every falling edge.
  always @(negedge clk) begin
    check("st_ready",    32'(st_ready),    32'(exp_ready));
    check("mem_req",     32'(mem_req),     32'(exp_req));
    check("done",        32'(done),        32'(exp_done));
    check("err",         32'(err),         32'(exp_err));
    check("err_code",    32'(err_code),    32'(exp_code));
    check("store_count", 32'(store_count), exp_count);
    if (exp_req) begin
      check("mem_addr",  mem_addr,      exp_addr);
      check("mem_wdata", mem_wdata,     exp_wdata);
      check("mem_be",    32'(mem_be),   32'(exp_be));
    end
    if (exp_be_zero) check("mem_be_fault", 32'(mem_be), 32'h0);
  end

  // One store: called just after a rising edge with the DUT idle.
  // gdelay = number of REQ cycles without grant before the grant cycle.
  task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] data, input int gdelay);
    logic [35:0] l;
    logic [1:0]  f;
    logic        g;
    l = lanes(size, addr, data);
    f = fault_of(size, addr);
    st_valid = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
    @(posedge clk); #1;
    st_valid = 1'b0;
    if (f != 2'b00) begin
      exp_ready   = 1'b0;
      exp_done    = 1'b1;
      exp_err     = 1'b1;
      exp_code    = f;
      exp_be_zero = 1'b1;
    end else begin
      exp_ready = 1'b0;
      exp_req   = 1'b1;
      exp_addr  = {addr[31:2], 2'b00};
      exp_wdata = l[31:0];
      exp_be    = l[35:32];
      for (int k = 0; k < TIMEOUT; k++) begin
        g = (k == gdelay);
        mem_gnt = g;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        if (g) begin
          exp_req   = 1'b0;
          exp_ready = 1'b1;
          exp_done  = 1'b1;
          exp_err   = 1'b0;
          exp_count = (exp_count == CNT_MAX) ? exp_count : exp_count + 1;
          break;
        end
        if (k == TIMEOUT - 1) begin
          exp_req   = 1'b0;
          exp_ready = 1'b1;
          exp_done  = 1'b1;
          exp_err   = 1'b1;
          exp_code  = 2'b11;
        end
      end
    end
    @(posedge clk); #1;
    exp_done    = 1'b0;
    exp_err     = 1'b0;
    exp_code    = 2'b00;
    exp_ready   = 1'b1;
    exp_be_zero = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [35:0] l;
    reset_n  = 1'b0;
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = 32'd0;
    st_data  = 32'd0;
    mem_gnt  = 1'b0;
    exp_ready = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_code = 2'b00; exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
    exp_be_zero = 1'b0; exp_count = 0;

    // Pin the model with hand-computed values.
    l = lanes(2'b00, 32'h1003, 32'hAABBCC5A);
    check("pin_byte_wdata", l[31:0], 32'h5A5A5A5A);
    check("pin_byte_be", 32'(l[35:32]), 32'h8);
    l = lanes(2'b01, 32'h2002, 32'h0000BEEF);
    check("pin_half_wdata", l[31:0], 32'hBEEFBEEF);
    check("pin_half_be", 32'(l[35:32]), 32'hC);
    check("pin_fault_word", 32'(fault_of(2'b10, 32'h3001)), 32'h1);
    check("pin_fault_size", 32'(fault_of(2'b11, 32'h3000)), 32'h2);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_mem_be", 32'(mem_be), 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Grant outside REQ is ignored.
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;

    do_store(2'b00, 32'h1003, 32'hAABBCC5A, 0);
    check("byte_count_literal", 32'(store_count), 32'h1);
    do_store(2'b01, 32'h2002, 32'h0000BEEF, 3);
    do_store(2'b01, 32'h2000, 32'h12345678, 1);
    do_store(2'b00, 32'h2001, 32'h000000C3, 2);

    // Faults, with a stray grant held high to show it is ignored.
    mem_gnt = 1'b1;
    do_store(2'b10, 32'h3001, 32'hDEADBEEF, 0);
    do_store(2'b11, 32'h3000, 32'hDEADBEEF, 0);
    do_store(2'b01, 32'h3003, 32'hDEADBEEF, 0);
    mem_gnt = 1'b0;

    // Timeout, then grant exactly on the last wait cycle.
    do_store(2'b10, 32'h5000, 32'hCAFEF00D, 99);
    check("timeout_count_literal", 32'(store_count), 32'h4);
    do_store(2'b10, 32'h5004, 32'h01020304, TIMEOUT - 1);
    check("grant_on_timeout_count", 32'(store_count), 32'h5);

    // Reset in the middle of a request.
    st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h4000; st_data = 32'h55AA55AA;
    @(posedge clk); #1;
    st_valid = 1'b0;
    exp_ready = 1'b0; exp_req = 1'b1; exp_addr = 32'h4000; exp_wdata = 32'h55AA55AA;
    exp_be = 4'hF;
    @(posedge clk); #1;
    #2;
    reset_n = 1'b0;
    exp_ready = 1'b1; exp_req = 1'b0; exp_count = 0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_st_ready", 32'(st_ready), 32'h1);
    check("rst_store_count", 32'(store_count), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_store(2'b10, 32'h4000, 32'h55AA55AA, 0);
    check("post_reset_count", 32'(store_count), 32'h1);

    // Drive the counter into saturation.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      do_store(2'b00, 32'h6000 + 32'(i), 32'(i * 7), i % 2);
    end
    check("saturated_count", 32'(store_count), 32'(CNT_MAX));

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
